// File: rtl/ntt_pkg.sv
// Shared constants and encodings for the NTT datapath and its controller.
package ntt_pkg;

    localparam int N           = 256;
    localparam int Q           = 3329;
    localparam int LAYERS      = 7;
    localparam int BF_LATENCY  = 5;
    localparam int RAM_LATENCY = 1;
    localparam int PAIRS       = N / 2;
    localparam int WR_DELAY    = RAM_LATENCY + BF_LATENCY;

    typedef enum logic [1:0] {
        BF_NTT    = 2'd0,
        BF_INTT   = 2'd1,
        BF_MULT   = 2'd2,
        BF_ADDSUB = 2'd3
    } bf_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/ntt_ctrl_if.sv
// Control, coefficient RAM, zeta ROM and butterfly signals of the NTT controller.
interface ntt_ctrl_if;

    logic        start;
    logic        inv;
    logic        busy;
    logic        done;
    logic        ram_rd_en;
    logic [7:0]  ram_rd_addr_a;
    logic [7:0]  ram_rd_addr_b;
    logic [11:0] ram_rd_data_a;
    logic [11:0] ram_rd_data_b;
    logic [6:0]  zeta_addr;
    logic [11:0] zeta_data;
    logic [11:0] bf_in_1;
    logic [11:0] bf_in_2;
    logic [11:0] bf_coef;
    logic [1:0]  bf_mode;
    logic [11:0] bf_out_1;
    logic [11:0] bf_out_2;
    logic        ram_wr_en;
    logic [7:0]  ram_wr_addr_a;
    logic [7:0]  ram_wr_addr_b;
    logic [11:0] ram_wr_data_a;
    logic [11:0] ram_wr_data_b;

    modport master (
        input  start, inv, ram_rd_data_a, ram_rd_data_b, zeta_data, bf_out_1, bf_out_2,
        output busy, done, ram_rd_en, ram_rd_addr_a, ram_rd_addr_b, zeta_addr,
               bf_in_1, bf_in_2, bf_coef, bf_mode,
               ram_wr_en, ram_wr_addr_a, ram_wr_addr_b, ram_wr_data_a, ram_wr_data_b
    );

    modport slave (
        output start, inv, ram_rd_data_a, ram_rd_data_b, zeta_data, bf_out_1, bf_out_2,
        input  busy, done, ram_rd_en, ram_rd_addr_a, ram_rd_addr_b, zeta_addr,
               bf_in_1, bf_in_2, bf_coef, bf_mode,
               ram_wr_en, ram_wr_addr_a, ram_wr_addr_b, ram_wr_data_a, ram_wr_data_b
    );

endinterface

// File: rtl/ntt_addr_gen.sv
// Butterfly pair addresses and zeta ROM index for layer s, pair p.
module ntt_addr_gen
    import ntt_pkg::*;
(
    input  logic [2:0] s,
    input  logic [6:0] p,
    input  logic       inv,
    output logic [7:0] addr_a,
    output logic [7:0] addr_b,
    output logic [6:0] zeta_addr
);

    logic [3:0] lg;
    logic [7:0] len;
    logic [6:0] g;
    logic [6:0] o;

    // len is always a power of two, so the divide/modulo reduce to shifts and masks
    always_comb begin
        lg        = inv ? ({1'b0, s} + 4'd1) : (4'd7 - {1'b0, s});
        len       = 8'd1 << lg;
        g         = p >> lg;
        o         = p & ~(7'h7f << lg);
        addr_a    = ({1'b0, g} << (lg + 4'd1)) + {1'b0, o};
        addr_b    = addr_a + len;
        // inverse: 256/len - 1 equals 127 >> (lg-1)
        zeta_addr = inv ? ((7'd127 >> (lg - 4'd1)) - g) : ((7'd1 << s) + g);
    end

endmodule

// File: rtl/ntt_ctrl.sv
// Layer/pair sequencer for an in-place 256-point NTT/INTT over a dual-port coefficient RAM.
//
//   state    | meaning
//   ST_IDLE  | waiting for start; done pulses here for one cycle after a run
//   ST_ISSUE | 128 cycles, one pair read per cycle for layer s
//   ST_DRAIN | 6 cycles letting the layer's writes land before the next layer reads
module ntt_ctrl
    import ntt_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    ntt_ctrl_if.master bus
);

    ctrl_state_e state, state_n;
    logic [2:0]  s, s_n;
    logic [6:0]  p, p_n;
    logic [2:0]  drain_cnt, drain_cnt_n;
    logic        done_q, done_n;
    logic        inv_q, inv_n;
    logic        issue;

    logic [7:0]  gen_addr_a;
    logic [7:0]  gen_addr_b;
    logic [6:0]  gen_zeta;

    logic [WR_DELAY-1:0] wr_v;
    logic [7:0]          wr_a [WR_DELAY];
    logic [7:0]          wr_b [WR_DELAY];

    ntt_addr_gen u_addr_gen (
        .s         (s),
        .p         (p),
        .inv       (inv_q),
        .addr_a    (gen_addr_a),
        .addr_b    (gen_addr_b),
        .zeta_addr (gen_zeta)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            s         <= '0;
            p         <= '0;
            drain_cnt <= '0;
            done_q    <= 1'b0;
            inv_q     <= 1'b0;
        end else begin
            state     <= state_n;
            s         <= s_n;
            p         <= p_n;
            drain_cnt <= drain_cnt_n;
            done_q    <= done_n;
            inv_q     <= inv_n;
        end
    end

    always_comb begin
        state_n     = state;
        s_n         = s;
        p_n         = p;
        drain_cnt_n = drain_cnt;
        done_n      = 1'b0;
        inv_n       = inv_q;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_n = ST_ISSUE;
                    s_n     = '0;
                    p_n     = '0;
                    inv_n   = bus.inv;
                end
            end
            ST_ISSUE: begin
                p_n = p + 7'd1;
                if (p == 7'(PAIRS - 1)) begin
                    state_n     = ST_DRAIN;
                    drain_cnt_n = 3'(WR_DELAY - 1);
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == 3'd0) begin
                    if (s == 3'(LAYERS - 1)) begin
                        state_n = ST_IDLE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = ST_ISSUE;
                        s_n     = s + 3'd1;
                        p_n     = '0;
                    end
                end else begin
                    drain_cnt_n = drain_cnt - 3'd1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign issue = (state == ST_ISSUE);

    // Write slots are the issued addresses delayed by RAM plus butterfly latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_v <= '0;
            for (int i = 0; i < WR_DELAY; i++) begin
                wr_a[i] <= '0;
                wr_b[i] <= '0;
            end
        end else begin
            wr_v    <= {wr_v[WR_DELAY-2:0], issue};
            wr_a[0] <= bus.ram_rd_addr_a;
            wr_b[0] <= bus.ram_rd_addr_b;
            for (int i = 1; i < WR_DELAY; i++) begin
                wr_a[i] <= wr_a[i-1];
                wr_b[i] <= wr_b[i-1];
            end
        end
    end

    assign bus.busy          = (state != ST_IDLE);
    assign bus.done          = done_q;
    assign bus.ram_rd_en     = issue;
    assign bus.ram_rd_addr_a = issue ? gen_addr_a : 8'd0;
    assign bus.ram_rd_addr_b = issue ? gen_addr_b : 8'd0;
    assign bus.zeta_addr     = issue ? gen_zeta : 7'd0;
    assign bus.bf_mode       = (bus.busy && inv_q) ? BF_INTT : BF_NTT;
    assign bus.bf_in_1       = bus.ram_rd_data_a;
    assign bus.bf_in_2       = bus.ram_rd_data_b;
    assign bus.bf_coef       = bus.zeta_data;
    assign bus.ram_wr_en     = wr_v[WR_DELAY-1];
    assign bus.ram_wr_addr_a = wr_a[WR_DELAY-1];
    assign bus.ram_wr_addr_b = wr_b[WR_DELAY-1];
    assign bus.ram_wr_data_a = bus.bf_out_1;
    assign bus.ram_wr_data_b = bus.bf_out_2;

endmodule

// File: tb/tb_ntt_ctrl.sv
// Directed checks of the NTT controller: reset, forward and inverse sequencing, write pipe, busy/done.
module tb_ntt_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    ntt_ctrl_if bus ();

    ntt_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int rd_cnt  = 0;
    int wr_cnt  = 0;
    int busy_cnt = 0;
    int hazards = 0;
    int mode_bad = 0;
    logic [1:0] exp_mode = 2'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.ram_rd_en === 1'b1) rd_cnt++;
        if (bus.ram_wr_en === 1'b1) wr_cnt++;
        if (bus.busy === 1'b1) begin
            busy_cnt++;
            if (bus.bf_mode !== exp_mode) mode_bad++;
        end
        if (bus.ram_rd_en === 1'b1 && bus.ram_wr_en === 1'b1 &&
            (bus.ram_rd_addr_a == bus.ram_wr_addr_a || bus.ram_rd_addr_a == bus.ram_wr_addr_b ||
             bus.ram_rd_addr_b == bus.ram_wr_addr_a || bus.ram_rd_addr_b == bus.ram_wr_addr_b))
            hazards++;
    endtask

    task automatic step_until(input int c);
        while (cyc < c) tick();
    endtask

    // Called just after an edge: the current cycle becomes cycle 0 with start high.
    task automatic start_run(input logic inv_v);
        bus.start = 1'b1;
        bus.inv   = inv_v;
        exp_mode  = inv_v ? 2'd1 : 2'd0;
        cyc       = 0;
        rd_cnt    = 0;
        wr_cnt    = 0;
        busy_cnt  = 0;
        hazards   = 0;
        mode_bad  = 0;
        tick();
        bus.start = 1'b0;
        bus.inv   = 1'b0;
    endtask

    initial begin
        bus.start         = 1'b0;
        bus.inv           = 1'b0;
        bus.ram_rd_data_a = 12'h0aa;
        bus.ram_rd_data_b = 12'h355;
        bus.zeta_data     = 12'h5a5;
        bus.bf_out_1      = 12'h000;
        bus.bf_out_2      = 12'h000;

        #2;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_rd_en", bus.ram_rd_en, 1'b0);
        check("rst_wr_en", bus.ram_wr_en, 1'b0);
        check("rst_rd_addr_b", bus.ram_rd_addr_b, 8'd0);
        check("rst_wr_addr_a", bus.ram_wr_addr_a, 8'd0);
        check("rst_zeta", bus.zeta_addr, 7'd0);
        check("rst_mode", bus.bf_mode, 2'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // Forward run
        start_run(1'b0);
        check("fwd_c1_busy", bus.busy, 1'b1);
        check("fwd_c1_rd_en", bus.ram_rd_en, 1'b1);
        check("fwd_c1_addr_a", bus.ram_rd_addr_a, 8'd0);
        check("fwd_c1_addr_b", bus.ram_rd_addr_b, 8'd128);
        check("fwd_c1_zeta", bus.zeta_addr, 7'd1);
        check("fwd_c1_mode", bus.bf_mode, 2'd0);
        check("pass_bf_in_1", bus.bf_in_1, 12'h0aa);
        check("pass_bf_in_2", bus.bf_in_2, 12'h355);
        check("pass_bf_coef", bus.bf_coef, 12'h5a5);
        step_until(2);
        check("fwd_c2_addr_a", bus.ram_rd_addr_a, 8'd1);
        check("fwd_c2_addr_b", bus.ram_rd_addr_b, 8'd129);
        step_until(6);
        check("fwd_c6_wr_en", bus.ram_wr_en, 1'b0);
        step_until(7);
        bus.bf_out_1 = 12'h123;
        bus.bf_out_2 = 12'habc;
        #1;
        check("wp_c7_wr_en", bus.ram_wr_en, 1'b1);
        check("wp_c7_wr_addr_a", bus.ram_wr_addr_a, 8'd0);
        check("wp_c7_wr_addr_b", bus.ram_wr_addr_b, 8'd128);
        check("wp_c7_wr_data_a", bus.ram_wr_data_a, 12'h123);
        check("wp_c7_wr_data_b", bus.ram_wr_data_b, 12'habc);
        step_until(128);
        check("fwd_c128_addr_a", bus.ram_rd_addr_a, 8'd127);
        check("fwd_c128_addr_b", bus.ram_rd_addr_b, 8'd255);
        step_until(129);
        check("fwd_c129_rd_en", bus.ram_rd_en, 1'b0);
        check("fwd_c129_busy", bus.busy, 1'b1);
        check("fwd_c129_addr_a", bus.ram_rd_addr_a, 8'd0);
        step_until(134);
        check("fwd_c134_wr_en", bus.ram_wr_en, 1'b1);
        check("fwd_c134_wr_addr_a", bus.ram_wr_addr_a, 8'd127);
        check("fwd_c134_rd_en", bus.ram_rd_en, 1'b0);
        step_until(135);
        check("fwd_c135_rd_en", bus.ram_rd_en, 1'b1);
        check("fwd_c135_addr_a", bus.ram_rd_addr_a, 8'd0);
        check("fwd_c135_addr_b", bus.ram_rd_addr_b, 8'd64);
        check("fwd_c135_zeta", bus.zeta_addr, 7'd2);
        check("fwd_c135_wr_en", bus.ram_wr_en, 1'b0);
        step_until(300);
        check("fwd_c300_addr_a", bus.ram_rd_addr_a, 8'd31);
        check("fwd_c300_addr_b", bus.ram_rd_addr_b, 8'd63);
        check("fwd_c300_zeta", bus.zeta_addr, 7'd4);
        bus.start = 1'b1;
        bus.inv   = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.inv   = 1'b0;
        check("ign_c301_busy", bus.busy, 1'b1);
        check("ign_c301_addr_a", bus.ram_rd_addr_a, 8'd64);
        check("ign_c301_addr_b", bus.ram_rd_addr_b, 8'd96);
        check("ign_c301_zeta", bus.zeta_addr, 7'd5);
        check("ign_c301_mode", bus.bf_mode, 2'd0);
        step_until(805);
        check("fwd_l6_addr_a", bus.ram_rd_addr_a, 8'd0);
        check("fwd_l6_addr_b", bus.ram_rd_addr_b, 8'd2);
        check("fwd_l6_zeta", bus.zeta_addr, 7'd64);
        step_until(938);
        check("fwd_c938_wr_en", bus.ram_wr_en, 1'b1);
        check("fwd_c938_wr_addr_a", bus.ram_wr_addr_a, 8'd253);
        check("fwd_c938_wr_addr_b", bus.ram_wr_addr_b, 8'd255);
        check("fwd_c938_busy", bus.busy, 1'b1);
        check("fwd_c938_done", bus.done, 1'b0);
        step_until(939);
        check("fwd_c939_done", bus.done, 1'b1);
        check("fwd_c939_busy", bus.busy, 1'b0);
        check("fwd_c939_wr_en", bus.ram_wr_en, 1'b0);
        check("fwd_rd_count", rd_cnt, 896);
        check("fwd_wr_count", wr_cnt, 896);
        check("fwd_busy_count", busy_cnt, 938);
        check("fwd_hazards", hazards, 0);
        check("fwd_mode_bad", mode_bad, 0);
        tick();
        check("fwd_c940_done", bus.done, 1'b0);

        // Inverse run
        start_run(1'b1);
        check("inv_c1_addr_a", bus.ram_rd_addr_a, 8'd0);
        check("inv_c1_addr_b", bus.ram_rd_addr_b, 8'd2);
        check("inv_c1_zeta", bus.zeta_addr, 7'd127);
        check("inv_c1_mode", bus.bf_mode, 2'd1);
        step_until(135);
        check("inv_l1_addr_a", bus.ram_rd_addr_a, 8'd0);
        check("inv_l1_addr_b", bus.ram_rd_addr_b, 8'd4);
        check("inv_l1_zeta", bus.zeta_addr, 7'd63);
        step_until(932);
        check("inv_last_addr_a", bus.ram_rd_addr_a, 8'd127);
        check("inv_last_addr_b", bus.ram_rd_addr_b, 8'd255);
        check("inv_last_zeta", bus.zeta_addr, 7'd1);
        step_until(939);
        check("inv_c939_done", bus.done, 1'b1);
        check("inv_c939_mode", bus.bf_mode, 2'd0);
        check("inv_mode_bad", mode_bad, 0);
        check("inv_rd_count", rd_cnt, 896);
        check("inv_hazards", hazards, 0);

        // Start on the done cycle is accepted
        start_run(1'b0);
        check("rst_run_c1_busy", bus.busy, 1'b1);
        check("rst_run_c1_addr_b", bus.ram_rd_addr_b, 8'd128);
        check("rst_run_c1_zeta", bus.zeta_addr, 7'd1);
        check("rst_run_c1_mode", bus.bf_mode, 2'd0);

        // Asynchronous abort mid-run
        step_until(300);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", bus.busy, 1'b0);
        check("abort_rd_en", bus.ram_rd_en, 1'b0);
        check("abort_wr_en", bus.ram_wr_en, 1'b0);
        check("abort_rd_addr_a", bus.ram_rd_addr_a, 8'd0);
        check("abort_zeta", bus.zeta_addr, 7'd0);
        check("abort_wr_addr_b", bus.ram_wr_addr_b, 8'd0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        wr_cnt = 0;
        rd_cnt = 0;
        for (int i = 0; i < 10; i++) tick();
        check("abort_no_writes", wr_cnt, 0);
        check("abort_no_reads", rd_cnt, 0);
        check("abort_idle", bus.busy, 1'b0);

        start_run(1'b0);
        check("fresh_c1_addr_a", bus.ram_rd_addr_a, 8'd0);
        check("fresh_c1_addr_b", bus.ram_rd_addr_b, 8'd128);
        step_until(7);
        check("fresh_c7_wr_addr_b", bus.ram_wr_addr_b, 8'd128);
        step_until(938);
        check("fresh_c938_done", bus.done, 1'b0);
        step_until(939);
        check("fresh_c939_done", bus.done, 1'b1);
        check("fresh_wr_count", wr_cnt, 896);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
